// File: rtl/afb_pkg.sv
// Shared constants for audio_frame_buffer: register word indices, CTRL/STATUS
// bit positions and the left/right capture FSM state encoding.
package afb_pkg;

    localparam logic [1:0] REG_CTRL        = 2'd0;
    localparam logic [1:0] REG_STATUS      = 2'd1;
    localparam logic [1:0] REG_FRAME_COUNT = 2'd2;
    localparam logic [1:0] REG_PEAK        = 2'd3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int STAT_FRAME_READY = 0;
    localparam int STAT_OVERRUN     = 1;
    localparam int STAT_READY_BANK  = 2;

    typedef enum logic {
        WAIT_L = 1'b0,
        WAIT_R = 1'b1
    } cap_state_e;

endpackage

// File: rtl/afb_pingpong_ram.sv
// Two-bank sample store: one write port, one registered read port, no reset on
// the array so the tools can map it onto block RAM.
module afb_pingpong_ram
    import afb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W:0]   i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W:0]   i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int DEPTH = 2 ** (ADDR_W + 1);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/audio_frame_buffer.sv
// Pairs L/R ADC samples, downmixes to mono into a ping-pong frame buffer and
// exposes finished frames over Avalon-MM. Optional peak tracker: AUDIO_FRAME_BUFFER_PEAK_EN.
module audio_frame_buffer
    import afb_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 512,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] left_data,
    input  logic              left_valid,
    output logic              left_ready,
    input  logic [DATA_W-1:0] right_data,
    input  logic              right_valid,
    output logic              right_ready,
    input  logic [ADDR_W:0]   avs_address,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    cap_state_e          r_state, w_state_next;
    logic [DATA_W-1:0]   r_left;
    logic [1:0]          r_ctrl;
    logic                r_frame_ready, r_overrun, r_ready_bank, r_wr_bank;
    logic [31:0]         r_frame_count;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic                r_frame_done;
    logic                r_irq;
    logic                r_rd_window;
    logic [31:0]         r_reg_rdata;

    logic                w_enable, w_left_hs, w_right_hs;
    logic signed [DATA_W:0] w_sum;
    logic [DATA_W-1:0]   w_mono;
    logic [DATA_W-1:0]   w_ram_rdata;
    logic [DATA_W-1:0]   w_peak;
    logic                w_reg_wr, w_reg_rd;
    logic [1:0]          w_reg_idx;
    logic                w_unused;

    assign w_enable  = r_ctrl[CTRL_ENABLE];
    assign w_reg_wr  = avs_write & ~avs_address[ADDR_W];
    assign w_reg_rd  = avs_read & ~avs_address[ADDR_W];
    assign w_reg_idx = avs_address[1:0];
    assign w_unused  = ^avs_writedata[31:2];

    // Sum at DATA_W+1 bits cannot overflow; dropping the LSB is an arithmetic floor.
    assign w_sum  = $signed({r_left[DATA_W-1], r_left}) + $signed({right_data[DATA_W-1], right_data});
    assign w_mono = w_sum[DATA_W:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_L;
            r_left  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_left_hs) begin
                r_left <= left_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        left_ready   = 1'b0;
        right_ready  = 1'b0;
        w_left_hs    = 1'b0;
        w_right_hs   = 1'b0;
        if (!w_enable) begin
            w_state_next = WAIT_L;
        end else begin
            case (r_state)
                WAIT_L: begin
                    left_ready = 1'b1;
                    if (left_valid) begin
                        w_left_hs    = 1'b1;
                        w_state_next = WAIT_R;
                    end
                end
                WAIT_R: begin
                    right_ready = 1'b1;
                    if (right_valid) begin
                        w_right_hs   = 1'b1;
                        w_state_next = WAIT_L;
                    end
                end
                default: w_state_next = WAIT_L;
            endcase
        end
    end

    // Frame completion is resolved one clock after the last write and is placed
    // after the host W1C so a simultaneous completion keeps frame_ready set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl        <= '0;
            r_frame_ready <= 1'b0;
            r_overrun     <= 1'b0;
            r_ready_bank  <= 1'b0;
            r_wr_bank     <= 1'b0;
            r_frame_count <= '0;
            r_wr_ptr      <= '0;
            r_frame_done  <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_frame_done <= w_right_hs && (r_wr_ptr == LAST_IDX);
            if (w_right_hs) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end else if (!w_enable) begin
                r_wr_ptr <= '0;
            end
            if (w_reg_wr && w_reg_idx == REG_CTRL) begin
                r_ctrl <= avs_writedata[1:0];
            end
            if (w_reg_wr && w_reg_idx == REG_STATUS) begin
                if (avs_writedata[STAT_FRAME_READY]) r_frame_ready <= 1'b0;
                if (avs_writedata[STAT_OVERRUN])     r_overrun     <= 1'b0;
            end
            if (r_frame_done) begin
                r_wr_ptr <= '0;
                if (!r_frame_ready) begin
                    r_ready_bank  <= r_wr_bank;
                    r_wr_bank     <= ~r_wr_bank;
                    r_frame_ready <= 1'b1;
                    r_frame_count <= r_frame_count + 32'd1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
            r_irq <= r_ctrl[CTRL_IRQ_EN] & (r_frame_ready | r_overrun);
        end
    end

    assign irq = r_irq;

`ifdef AUDIO_FRAME_BUFFER_PEAK_EN
    logic [DATA_W-1:0] w_abs;
    logic [DATA_W-1:0] r_run_max, r_peak;

    // |most negative| does not fit, so it saturates to the largest positive value.
    always_comb begin
        w_abs = w_mono;
        if (w_mono[DATA_W-1]) begin
            if (w_mono == {1'b1, {(DATA_W-1){1'b0}}}) begin
                w_abs = {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                w_abs = -w_mono;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_max <= '0;
            r_peak    <= '0;
        end else if (r_frame_done) begin
            if (!r_frame_ready) begin
                r_peak <= r_run_max;
            end
            r_run_max <= '0;
        end else if (!w_enable) begin
            r_run_max <= '0;
        end else if (w_right_hs && (w_abs > r_run_max)) begin
            r_run_max <= w_abs;
        end
    end

    assign w_peak = r_peak;
`else
    assign w_peak = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_window <= 1'b0;
            r_reg_rdata <= '0;
        end else begin
            r_rd_window <= avs_read & avs_address[ADDR_W];
            if (w_reg_rd) begin
                case (w_reg_idx)
                    REG_CTRL:        r_reg_rdata <= {30'd0, r_ctrl};
                    REG_STATUS:      r_reg_rdata <= {29'd0, r_ready_bank, r_overrun, r_frame_ready};
                    REG_FRAME_COUNT: r_reg_rdata <= r_frame_count;
                    default:         r_reg_rdata <= 32'(w_peak);
                endcase
            end
        end
    end

    assign avs_readdata = r_rd_window ? 32'($signed(w_ram_rdata)) : r_reg_rdata;

    afb_pingpong_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_right_hs),
        .i_wr_addr ({r_wr_bank, r_wr_ptr}),
        .i_wr_data (w_mono),
        .i_rd_en   (avs_read & avs_address[ADDR_W]),
        .i_rd_addr ({r_ready_bank, avs_address[ADDR_W-1:0]}),
        .o_rd_data (w_ram_rdata)
    );

endmodule
